stage3_k_module: RTL and testbench
==================================

# stage3_k_module

Category-K quote merge stage. It takes the up-to-three formatted 35-byte quote messages produced per cycle by the stage-2 K formatter and packs them into a FIFO, then drains them one per cycle on a single valid/ready stream toward the output framer. Market data cannot be back-pressured, so a group that arrives while the FIFO lacks room is dropped, never stalled.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 4.
- MSG_W, `MAX_MESSAGE_BITS: message width (from para_def.v).

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- message_k_1  input  MSG_W  lane-1 formatted message.
- message_k_2  input  MSG_W  lane-2 formatted message.
- message_k_3  input  MSG_W  lane-3 formatted message.
- valid_k  input  3  per-lane valid; bit0 = lane 1, bit2 = lane 3; any bit set forms a group.
- in_ready  output  1  high when free entries ≥ 3; forced 0 while rst is high.
- message_out  output  MSG_W  FIFO head message.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accept.
- drop_cnt  output  16  dropped-group counter; present only with STAGE3_K_DROP_CNT_EN.

## Operation
- Storage: DEPTH×MSG_W register array, rd_ptr and wr_ptr of log2(DEPTH) bits each wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- Write: when valid_k != 0 and in_ready = 1, write valid lanes in lane order 1→2→3, skipping invalid lanes, into consecutive slots from wr_ptr. nwr = popcount(valid_k), 0–3. wr_ptr += nwr.
  - Example: valid_k = 3'b101 writes lane 1 at wr_ptr and lane 3 at wr_ptr+1.
- Read: a pop occurs when out_valid & out_ready. rd_ptr += 1.
- count_next = count + (accepted ? nwr : 0) − pop. A simultaneous write and pop is legal in every state, including count = DEPTH−3 and count = 0. A write does not bypass to the output in the same cycle.
- Drop: when valid_k != 0 and in_ready = 0, the whole group is discarded, with no partial write. Pointers are unchanged.
- message_out = mem[rd_ptr]. Its value is don't-care when out_valid = 0.
- Pointer wrap: writes straddling DEPTH−1→0 wrap per slot.
- No state machine beyond the pointers and count. Status: EMPTY (count = 0), NORMAL, NEAR_FULL (count > DEPTH−3, in_ready low).

## Timing
- Reset values: rd_ptr = 0, wr_ptr = 0, count = 0, out_valid = 0, in_ready = 0 during rst, drop_cnt = 0.
- in_ready = 1 from the first cycle after rst falls.
- in_ready is combinational from registered count only. It has no path from valid_k or out_ready.
- Latency: a group accepted at edge N makes out_valid = 1 with the lane-order-first message on message_out in the cycle after edge N.
- Throughput: drain is 1 message per cycle. Sustained input above 1 message per cycle fills the FIFO and causes drops.
- message_out and out_valid hold stable while out_valid = 1 and out_ready = 0.
- Reset mid-operation: all contents are discarded and pointers return to 0 at the reset edge. out_valid = 0 in the following cycle. drop_cnt clears.

## Configuration
- STAGE3_K_DROP_CNT_EN defined:
  - drop_cnt port exists.
  - It increments by 1 on each dropped group and saturates at 16'hFFFF.
  - A drop in the same cycle as reset is not counted.
- Not defined:
  - The drop_cnt port and its counter are omitted.
  - Drop behaviour is otherwise identical.

## Test plan
- Reset, then one cycle of valid_k = 3'b111 with messages A, B, C, out_ready = 1 → out_valid from the next cycle; A, B, C on three consecutive cycles; then out_valid = 0, count = 0.
- valid_k = 3'b101 (lanes 1 = D, 3 = F) with out_ready = 1 → exactly D then F; lane 2 is never emitted.
- DEPTH = 8, out_ready = 0, three groups of 3'b111 → the first two are accepted (count = 6) and in_ready drops; the third is dropped with drop_cnt = 1 (macro on); releasing out_ready drains 6 messages in order.
- count = 5 with pop and a 3-lane write in the same cycle → write accepted, count becomes 7; the wrap-around across slot 7→0 preserves order.
- Reset asserted with 4 messages queued → the next cycle has out_valid = 0 and in_ready = 0; after release in_ready = 1, and a new group is emitted with none of the old data.

Source files
------------

// File: rtl/stage3_k_module.sv
// Category-K quote merge stage: packs up to three lane messages per cycle into a FIFO and drains one per cycle.
// Optional feature macro: STAGE3_K_DROP_CNT_EN adds the saturating drop_cnt output.
`ifndef MAX_MESSAGE_BITS
`define MAX_MESSAGE_BITS 280
`endif

module stage3_k_module #(
    parameter int DEPTH = 8,
    parameter int MSG_W = `MAX_MESSAGE_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MSG_W-1:0] message_k_1,
    input  logic [MSG_W-1:0] message_k_2,
    input  logic [MSG_W-1:0] message_k_3,
    input  logic [2:0]       valid_k,
    output logic             in_ready,
    output logic [MSG_W-1:0] message_out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef STAGE3_K_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [MSG_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;

    logic [1:0]       w_nwr;
    logic [AW:0]      w_free;
    logic [AW:0]      w_add;
    logic [AW:0]      w_sub;
    logic             w_group;
    logic             w_accept;
    logic             w_pop;
    logic [AW-1:0]    w_slot2;
    logic [AW-1:0]    w_slot3;

    always_comb begin
        w_nwr    = 2'(valid_k[0]) + 2'(valid_k[1]) + 2'(valid_k[2]);
        w_free   = (AW+1)'(DEPTH) - r_count;
        w_group  = |valid_k;
        // in_ready depends only on registered count (and reset), never on valid_k/out_ready
        in_ready = ~rst & (w_free >= (AW+1)'(3));
        w_accept = w_group & in_ready;
        out_valid   = (r_count != '0);
        message_out = r_mem[r_rd_ptr];
        w_pop    = out_valid & out_ready;
        w_add    = w_accept ? (AW+1)'(w_nwr) : '0;
        w_sub    = w_pop ? (AW+1)'(1) : '0;
        // Valid lanes pack into consecutive slots; pointer arithmetic wraps modulo DEPTH
        w_slot2  = r_wr_ptr + AW'(valid_k[0]);
        w_slot3  = r_wr_ptr + AW'(valid_k[0]) + AW'(valid_k[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_accept)
                r_wr_ptr <= r_wr_ptr + AW'(w_nwr);
            r_count <= r_count + w_add - w_sub;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (valid_k[0])
                r_mem[r_wr_ptr] <= message_k_1;
            if (valid_k[1])
                r_mem[w_slot2] <= message_k_2;
            if (valid_k[2])
                r_mem[w_slot3] <= message_k_3;
        end
    end

`ifdef STAGE3_K_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    assign w_drop   = w_group & ~in_ready & ~rst;
    assign drop_cnt = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_drop_cnt <= '0;
        else if (w_drop && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_stage3_k_module.sv
// Self-checking bench for stage3_k_module: queue-based reference model, directed scenarios, then random traffic.
// Checks drop_cnt as well when STAGE3_K_DROP_CNT_EN is defined.
`timescale 1ns/1ps

module tb_stage3_k_module;

    localparam int DEPTH = 8;
    localparam int MSG_W = 280;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [MSG_W-1:0] message_k_1 = '0;
    logic [MSG_W-1:0] message_k_2 = '0;
    logic [MSG_W-1:0] message_k_3 = '0;
    logic [2:0]       valid_k = '0;
    logic             in_ready;
    logic [MSG_W-1:0] message_out;
    logic             out_valid;
    logic             out_ready = 1'b0;
`ifdef STAGE3_K_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [MSG_W-1:0] m_q[$];
    int unsigned      m_drop = 0;
    bit               m_live = 1'b0;

    always #5 clk = ~clk;

    stage3_k_module #(.DEPTH(DEPTH), .MSG_W(MSG_W)) dut (
        .clk(clk),
        .rst(rst),
        .message_k_1(message_k_1),
        .message_k_2(message_k_2),
        .message_k_3(message_k_3),
        .valid_k(valid_k),
        .in_ready(in_ready),
        .message_out(message_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef STAGE3_K_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue, room judged on occupancy before this edge's pop.
    always @(posedge clk) begin
        bit acc;
        bit pop;
        m_live = 1'b1;
        if (rst) begin
            m_q.delete();
            m_drop = 0;
        end else begin
            pop = (m_q.size() != 0) && out_ready;
            acc = (valid_k != 3'b000) && (m_q.size() <= DEPTH - 3);
            if (valid_k != 3'b000 && !acc && m_drop < 16'hFFFF)
                m_drop++;
            if (pop)
                void'(m_q.pop_front());
            if (acc) begin
                if (valid_k[0]) m_q.push_back(message_k_1);
                if (valid_k[1]) m_q.push_back(message_k_2);
                if (valid_k[2]) m_q.push_back(message_k_3);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready", MSG_W'(in_ready), MSG_W'(!rst && (m_q.size() <= DEPTH - 3)));
            check("out_valid", MSG_W'(out_valid), MSG_W'(m_q.size() != 0));
            if (m_q.size() != 0)
                check("message_out", message_out, m_q[0]);
`ifdef STAGE3_K_DROP_CNT_EN
            check("drop_cnt", MSG_W'(drop_cnt), MSG_W'(m_drop));
`endif
        end
    end

    // Drive inputs just after a rising edge, hold for one full cycle.
    task automatic drive(input logic r, input logic [2:0] v,
                         input logic [MSG_W-1:0] a, input logic [MSG_W-1:0] b,
                         input logic [MSG_W-1:0] c, input logic o);
        rst = r;
        valid_k = v;
        message_k_1 = a;
        message_k_2 = b;
        message_k_3 = c;
        out_ready = o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic o);
        drive(1'b0, 3'b000, '0, '0, '0, o);
    endtask

    function automatic logic [MSG_W-1:0] rand_msg();
        logic [MSG_W-1:0] m;
        m = '0;
        for (int i = 0; i < (MSG_W + 31) / 32; i++)
            m = (m << 32) | MSG_W'($urandom);
        return m;
    endfunction

    function automatic logic [MSG_W-1:0] tag(input int unsigned t);
        return MSG_W'(t);
    endfunction

    initial begin
        logic [MSG_W-1:0] a, b, c;

        drive(1'b1, 3'b000, '0, '0, '0, 1'b0);
        drive(1'b1, 3'b111, tag(9), tag(9), tag(9), 1'b0);
        check("reset_out_valid", MSG_W'(out_valid), '0);
        check("reset_in_ready", MSG_W'(in_ready), '0);
        idle(1'b1);
        check("post_reset_in_ready", MSG_W'(in_ready), MSG_W'(1));

        // A, B, C in one group, drained on consecutive cycles
        drive(1'b0, 3'b111, tag('hA), tag('hB), tag('hC), 1'b1);
        check("abc_first_valid", MSG_W'(out_valid), MSG_W'(1));
        check("abc_first", message_out, tag('hA));
        idle(1'b1);
        check("abc_second", message_out, tag('hB));
        idle(1'b1);
        check("abc_third", message_out, tag('hC));
        idle(1'b1);
        check("abc_empty", MSG_W'(out_valid), '0);

        // Lane 2 skipped
        drive(1'b0, 3'b101, tag('hD), tag('hE), tag('hF), 1'b1);
        check("df_first", message_out, tag('hD));
        idle(1'b1);
        check("df_second", message_out, tag('hF));
        idle(1'b1);
        check("df_empty", MSG_W'(out_valid), '0);

        // Fill to 6, third group dropped, drain across the 7->0 wrap
        drive(1'b0, 3'b111, tag(1), tag(2), tag(3), 1'b0);
        drive(1'b0, 3'b111, tag(4), tag(5), tag(6), 1'b0);
        check("full_in_ready", MSG_W'(in_ready), '0);
        drive(1'b0, 3'b111, tag(7), tag(8), tag(9), 1'b0);
`ifdef STAGE3_K_DROP_CNT_EN
        check("drop_cnt_one", MSG_W'(drop_cnt), MSG_W'(1));
`endif
        for (int unsigned i = 1; i <= 6; i++) begin
            check("drain_order", message_out, tag(i));
            idle(1'b1);
        end
        check("drain_empty", MSG_W'(out_valid), '0);

        // count 5, then pop plus 3-lane write in the same cycle -> count 7
        drive(1'b0, 3'b111, tag('h11), tag('h12), tag('h13), 1'b0);
        drive(1'b0, 3'b101, tag('h14), tag('h00), tag('h15), 1'b0);
        check("count5_in_ready", MSG_W'(in_ready), MSG_W'(1));
        drive(1'b0, 3'b111, tag('h16), tag('h17), tag('h18), 1'b1);
        check("count7_in_ready", MSG_W'(in_ready), '0);
        check("count7_head", message_out, tag('h12));
        for (int unsigned i = 0; i < 8; i++)
            idle(1'b1);
        check("count7_empty", MSG_W'(out_valid), '0);

        // Reset with 4 queued messages discards them
        drive(1'b0, 3'b111, tag('h21), tag('h22), tag('h23), 1'b0);
        drive(1'b0, 3'b001, tag('h24), tag('h00), tag('h00), 1'b0);
        drive(1'b1, 3'b111, tag('h25), tag('h26), tag('h27), 1'b0);
        check("midreset_out_valid", MSG_W'(out_valid), '0);
        check("midreset_in_ready", MSG_W'(in_ready), '0);
        idle(1'b0);
        check("release_in_ready", MSG_W'(in_ready), MSG_W'(1));
        check("release_out_valid", MSG_W'(out_valid), '0);
        drive(1'b0, 3'b010, tag('h30), tag('h31), tag('h32), 1'b1);
        check("fresh_head", message_out, tag('h31));
        idle(1'b1);
        check("fresh_empty", MSG_W'(out_valid), '0);

        // Random traffic against the model
        for (int unsigned i = 0; i < 3000; i++) begin
            a = rand_msg();
            b = rand_msg();
            c = rand_msg();
            drive(($urandom_range(0, 249) == 0), 3'($urandom_range(0, 7)), a, b, c,
                  ($urandom_range(0, 2) != 0));
        end
        for (int unsigned i = 0; i < DEPTH + 2; i++)
            idle(1'b1);
        check("final_empty", MSG_W'(out_valid), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
